ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register plus operand-select and forwarding logic sitting directly upstream of the ALU. It captures decoded instructions from the decode stage, resolves data hazards by forwarding from EX/MEM and MEM/WB, and applies immediate/PC selection and shift-amount masking. It presents `SrcA`, `SrcB` and `Operation` to the ALU every cycle. Stall holds the current instruction; flush inserts a bubble.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rd1`, `id_rd2`  in  DATA_WIDTH  register file read data
- `id_imm`  in  DATA_WIDTH  sign-extended immediate
- `id_pc`  in  DATA_WIDTH  instruction PC
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR  source/destination indices
- `id_a_sel_pc`  in  1  SrcA = PC instead of rs1
- `id_b_sel_imm`  in  1  SrcB = immediate instead of rs2
- `id_operation`  in  OPCODE_LENGTH  ALU operation
- `id_reg_write`  in  1  instruction writes rd
- `stall`  in  1  hold current EX contents
- `flush`  in  1  replace EX contents with bubble
- `exmem_reg_write`, `memwb_reg_write`  in  1  later-stage write enables
- `exmem_rd`, `memwb_rd`  in  REG_ADDR  later-stage destinations
- `exmem_result`, `memwb_result`  in  DATA_WIDTH  later-stage results
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU operation
- `ex_valid`  out  1  EX slot holds a real instruction
- `ex_rd`  out  REG_ADDR  destination index
- `ex_reg_write`  out  1  qualified write enable (`ex_valid & stored reg_write`)
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 value (for stores)
- `ex_pc`  out  DATA_WIDTH  stored PC
- `bubble_count`  out  16  saturating count of cycles with `ex_valid`=0

## Operation
- Register update priority per edge: `reset` > `flush` > `stall` > load.
  - reset: all stored fields 0, `ex_valid`=0, `bubble_count`=0.
  - flush: `ex_valid`=0, stored reg_write=0; other fields don't-care but cleared to 0.
  - stall: fields held, except stored rd1/rd2 are overwritten with their current forwarded values. A result retiring from MEM/WB during a stall is therefore not lost.
  - load: all `id_*` fields captured.
- Forwarding, combinational from stored rs1/rs2:
  - EX/MEM match (`exmem_reg_write`, `exmem_rd`==rs, rs≠0) has priority over MEM/WB match.
  - Else stored rd value.
  - Index 0 never forwards.
- `SrcA` = `ex_pc` if a_sel_pc, else fwdA.
- `SrcB` = imm if b_sel_imm, else fwdB.
- Shift masking: if `Operation` ∈ {3 SLLI, 4 SRLI, 6 SRAI}, `SrcB[DATA_WIDTH-1:5]` forced to 0, so only the low 5 bits are used as the shift amount.
- `ex_store_data` = fwdB, regardless of b_sel_imm.
- Bubble output (`ex_valid`=0): `SrcA`=0, `SrcB`=0, `Operation`=4'b0010 (ADD, ALU yields 0), `ex_reg_write`=0.
- `bubble_count` increments on each edge where post-edge `ex_valid`=0 and reset is not asserted; saturates at 16'hFFFF.

## Timing
- Latency: `id_*` captured on edge N; operands valid at outputs after edge N, in the same cycle. Forwarding adds zero cycles.
- Forwarding inputs are sampled combinationally; outputs follow them within the cycle.
- Reset values: `SrcA`=0, `SrcB`=0, `Operation`=4'b0010, `ex_valid`=0, `ex_rd`=0, `ex_reg_write`=0, `ex_store_data`=0, `ex_pc`=0, `bubble_count`=0.
- `stall` and `flush` together: flush wins, producing a bubble.
- `reset` mid-stall or mid-flush: reset wins; state after the edge equals the reset state.
- `id_valid`=0 on load: loads a bubble, identical to flush.

## Test plan
- Reset then load ADD with rd1=5, rd2=7, no hazards -> next cycle `SrcA`=5, `SrcB`=7, `Operation`=2, `ex_valid`=1.
- rs1=3 with `exmem_rd`=3/`exmem_result`=100 and `memwb_rd`=3/`memwb_result`=200, both write-enabled -> `SrcA`=100. Same with rs1=0 -> `SrcA`=stored rd1.
- SLLI, imm=32'h0000_0423, b_sel_imm=1 -> `SrcB`=32'h3. SRAI behaves the same; ADD with same imm -> `SrcB`=32'h423.
- Stall 2 cycles while MEM/WB writes rs2 (value 55) only in stall cycle 1 -> in cycle 2, `SrcB`=55 and `ex_store_data`=55.
- `stall`=1 and `flush`=1 together -> `ex_valid`=0, `SrcA`=`SrcB`=0, `Operation`=2, `ex_reg_write`=0, `bubble_count`+1.
- Hold flush for 70000 cycles -> `bubble_count`=16'hFFFF. Reset asserted mid-run -> `bubble_count`=0 the next cycle.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// Bundle between decode/hazard control and the EX operand stage.
// Handshake: id_valid qualifies the decode slot; an instruction is taken on
// a rising edge when id_valid=1 and neither stall nor flush nor reset is set.
// stall is the back-pressure signal (hold EX), flush discards the EX slot.
// ex_valid qualifies everything the stage presents to the ALU and later stages.
interface ex_operand_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int REG_ADDR      = 5
);
   logic                     id_valid;
   logic [DATA_WIDTH-1:0]    id_rd1;
   logic [DATA_WIDTH-1:0]    id_rd2;
   logic [DATA_WIDTH-1:0]    id_imm;
   logic [DATA_WIDTH-1:0]    id_pc;
   logic [REG_ADDR-1:0]      id_rs1;
   logic [REG_ADDR-1:0]      id_rs2;
   logic [REG_ADDR-1:0]      id_rd;
   logic                     id_a_sel_pc;
   logic                     id_b_sel_imm;
   logic [OPCODE_LENGTH-1:0] id_operation;
   logic                     id_reg_write;
   logic                     stall;
   logic                     flush;
   logic                     exmem_reg_write;
   logic                     memwb_reg_write;
   logic [REG_ADDR-1:0]      exmem_rd;
   logic [REG_ADDR-1:0]      memwb_rd;
   logic [DATA_WIDTH-1:0]    exmem_result;
   logic [DATA_WIDTH-1:0]    memwb_result;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic                     ex_valid;
   logic [REG_ADDR-1:0]      ex_rd;
   logic                     ex_reg_write;
   logic [DATA_WIDTH-1:0]    ex_store_data;
   logic [DATA_WIDTH-1:0]    ex_pc;
   logic [15:0]              bubble_count;

   // Driver side (decode stage, hazard unit, later stages).
   modport master (
      output id_valid, id_rd1, id_rd2, id_imm, id_pc, id_rs1, id_rs2, id_rd,
             id_a_sel_pc, id_b_sel_imm, id_operation, id_reg_write,
             stall, flush, exmem_reg_write, memwb_reg_write, exmem_rd,
             memwb_rd, exmem_result, memwb_result,
      input  SrcA, SrcB, Operation, ex_valid, ex_rd, ex_reg_write,
             ex_store_data, ex_pc, bubble_count
   );

   // The operand stage itself.
   modport slave (
      input  id_valid, id_rd1, id_rd2, id_imm, id_pc, id_rs1, id_rs2, id_rd,
             id_a_sel_pc, id_b_sel_imm, id_operation, id_reg_write,
             stall, flush, exmem_reg_write, memwb_reg_write, exmem_rd,
             memwb_rd, exmem_result, memwb_result,
      output SrcA, SrcB, Operation, ex_valid, ex_rd, ex_reg_write,
             ex_store_data, ex_pc, bubble_count
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding, PC/immediate
// operand selection and shift-amount masking, feeding the ALU directly.
module ex_operand_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int REG_ADDR      = 5
) (
   input logic                clk,
   input logic                reset,
   ex_operand_stage_if.slave  bus
);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(2);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLLI = OPCODE_LENGTH'(3);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRLI = OPCODE_LENGTH'(4);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRAI = OPCODE_LENGTH'(6);
   localparam logic [DATA_WIDTH-1:0]    SHAMT_MASK =
      {{(DATA_WIDTH-5){1'b0}}, 5'h1f};

   logic                     valid_q, valid_d;
   logic [DATA_WIDTH-1:0]    rd1_q, rd1_d;
   logic [DATA_WIDTH-1:0]    rd2_q, rd2_d;
   logic [DATA_WIDTH-1:0]    imm_q, imm_d;
   logic [DATA_WIDTH-1:0]    pc_q, pc_d;
   logic [REG_ADDR-1:0]      rs1_q, rs1_d;
   logic [REG_ADDR-1:0]      rs2_q, rs2_d;
   logic [REG_ADDR-1:0]      rd_q, rd_d;
   logic                     a_sel_pc_q, a_sel_pc_d;
   logic                     b_sel_imm_q, b_sel_imm_d;
   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic                     reg_write_q, reg_write_d;
   logic [15:0]              bubble_count_q, bubble_count_d;

   logic [DATA_WIDTH-1:0]    fwd_a;
   logic [DATA_WIDTH-1:0]    fwd_b;
   logic [DATA_WIDTH-1:0]    src_b_sel;
   logic                     is_shift_imm;

   // Forwarding: youngest producer (EX/MEM) wins; register 0 never forwards.
   always_comb begin
      fwd_a = rd1_q;
      if (bus.exmem_reg_write && (bus.exmem_rd == rs1_q) && (rs1_q != '0))
         fwd_a = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd == rs1_q) && (rs1_q != '0))
         fwd_a = bus.memwb_result;

      fwd_b = rd2_q;
      if (bus.exmem_reg_write && (bus.exmem_rd == rs2_q) && (rs2_q != '0))
         fwd_b = bus.exmem_result;
      else if (bus.memwb_reg_write && (bus.memwb_rd == rs2_q) && (rs2_q != '0))
         fwd_b = bus.memwb_result;
   end

   // Next-state selection: flush (or an empty decode slot) > stall > load.
   always_comb begin
      valid_d     = valid_q;
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      a_sel_pc_d  = a_sel_pc_q;
      b_sel_imm_d = b_sel_imm_q;
      op_d        = op_q;
      reg_write_d = reg_write_q;

      if (bus.flush || (!bus.stall && !bus.id_valid)) begin
         valid_d     = 1'b0;
         rd1_d       = '0;
         rd2_d       = '0;
         imm_d       = '0;
         pc_d        = '0;
         rs1_d       = '0;
         rs2_d       = '0;
         rd_d        = '0;
         a_sel_pc_d  = 1'b0;
         b_sel_imm_d = 1'b0;
         op_d        = '0;
         reg_write_d = 1'b0;
      end else if (bus.stall) begin
         // Capture forwarded values so a result retiring during the stall
         // is still seen once the producer has left the pipeline.
         rd1_d = fwd_a;
         rd2_d = fwd_b;
      end else begin
         valid_d     = 1'b1;
         rd1_d       = bus.id_rd1;
         rd2_d       = bus.id_rd2;
         imm_d       = bus.id_imm;
         pc_d        = bus.id_pc;
         rs1_d       = bus.id_rs1;
         rs2_d       = bus.id_rs2;
         rd_d        = bus.id_rd;
         a_sel_pc_d  = bus.id_a_sel_pc;
         b_sel_imm_d = bus.id_b_sel_imm;
         op_d        = bus.id_operation;
         reg_write_d = bus.id_reg_write;
      end

      // Counts cycles that will follow this edge with an empty EX slot.
      bubble_count_d = bubble_count_q;
      if (!valid_d && (bubble_count_q != 16'hFFFF))
         bubble_count_d = bubble_count_q + 16'd1;
   end

   // Pipeline register and bubble counter, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q        <= 1'b0;
         rd1_q          <= '0;
         rd2_q          <= '0;
         imm_q          <= '0;
         pc_q           <= '0;
         rs1_q          <= '0;
         rs2_q          <= '0;
         rd_q           <= '0;
         a_sel_pc_q     <= 1'b0;
         b_sel_imm_q    <= 1'b0;
         op_q           <= '0;
         reg_write_q    <= 1'b0;
         bubble_count_q <= '0;
      end else begin
         valid_q        <= valid_d;
         rd1_q          <= rd1_d;
         rd2_q          <= rd2_d;
         imm_q          <= imm_d;
         pc_q           <= pc_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         rd_q           <= rd_d;
         a_sel_pc_q     <= a_sel_pc_d;
         b_sel_imm_q    <= b_sel_imm_d;
         op_q           <= op_d;
         reg_write_q    <= reg_write_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   // ALU operands: bubble forces ADD 0+0; shift immediates keep only 5 bits.
   always_comb begin
      is_shift_imm = (op_q == OP_SLLI) || (op_q == OP_SRLI) || (op_q == OP_SRAI);
      src_b_sel    = b_sel_imm_q ? imm_q : fwd_b;
      if (is_shift_imm)
         src_b_sel = src_b_sel & SHAMT_MASK;

      if (valid_q) begin
         bus.SrcA      = a_sel_pc_q ? pc_q : fwd_a;
         bus.SrcB      = src_b_sel;
         bus.Operation = op_q;
      end else begin
         bus.SrcA      = '0;
         bus.SrcB      = '0;
         bus.Operation = OP_ADD;
      end
   end

   assign bus.ex_valid      = valid_q;
   assign bus.ex_rd         = rd_q;
   assign bus.ex_reg_write  = valid_q & reg_write_q;
   assign bus.ex_store_data = fwd_b;
   assign bus.ex_pc         = pc_q;
   assign bus.bubble_count  = bubble_count_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, load, forwarding priority,
// operand selection, shift masking, stall capture, flush and bubble counter.
module tb_ex_operand_stage;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   ex_operand_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR(5)) bus ();

   ex_operand_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic a_pc,
                         input logic b_imm, input logic [3:0] op,
                         input logic rw);
      bus.id_valid     = 1'b1;
      bus.id_rd1       = rd1;
      bus.id_rd2       = rd2;
      bus.id_imm       = imm;
      bus.id_pc        = pc;
      bus.id_rs1       = rs1;
      bus.id_rs2       = rs2;
      bus.id_rd        = rd;
      bus.id_a_sel_pc  = a_pc;
      bus.id_b_sel_imm = b_imm;
      bus.id_operation = op;
      bus.id_reg_write = rw;
   endtask

   task automatic fwd_off();
      bus.exmem_reg_write = 1'b0;
      bus.memwb_reg_write = 1'b0;
      bus.exmem_rd        = 5'd0;
      bus.memwb_rd        = 5'd0;
      bus.exmem_result    = 32'd0;
      bus.memwb_result    = 32'd0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      set_id(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      bus.id_valid = 1'b0;
      fwd_off();
      tick();
      tick();

      // Reset state
      chk("rst_srca", bus.SrcA, 32'd0);
      chk("rst_srcb", bus.SrcB, 32'd0);
      chk("rst_op", 32'(bus.Operation), 32'd2);
      chk("rst_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst_rd", 32'(bus.ex_rd), 32'd0);
      chk("rst_rw", 32'(bus.ex_reg_write), 32'd0);
      chk("rst_store", bus.ex_store_data, 32'd0);
      chk("rst_pc", bus.ex_pc, 32'd0);
      chk("rst_bc", 32'(bus.bubble_count), 32'd0);
      reset = 1'b0;

      // Plain ADD, no hazards
      set_id(32'd5, 32'd7, 32'd0, 32'h100, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 4'd2, 1'b1);
      tick();
      chk("add_srca", bus.SrcA, 32'd5);
      chk("add_srcb", bus.SrcB, 32'd7);
      chk("add_op", 32'(bus.Operation), 32'd2);
      chk("add_valid", 32'(bus.ex_valid), 32'd1);
      chk("add_rw", 32'(bus.ex_reg_write), 32'd1);
      chk("add_rd", 32'(bus.ex_rd), 32'd4);
      chk("add_pc", bus.ex_pc, 32'h100);
      chk("add_store", bus.ex_store_data, 32'd7);
      chk("add_bc", 32'(bus.bubble_count), 32'd0);

      // Forwarding priority on rs1=3, rs2=2
      set_id(32'd11, 32'd22, 32'd0, 32'h104, 5'd3, 5'd2, 5'd5, 1'b0, 1'b0, 4'd2, 1'b1);
      tick();
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'd100;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'd200;
      #1;
      chk("fwd_exmem_prio", bus.SrcA, 32'd100);
      chk("fwd_b_nomatch", bus.SrcB, 32'd22);
      bus.exmem_reg_write = 1'b0;
      #1;
      chk("fwd_memwb", bus.SrcA, 32'd200);
      bus.memwb_reg_write = 1'b0;
      #1;
      chk("fwd_none", bus.SrcA, 32'd11);
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd2; bus.exmem_result = 32'd77;
      #1;
      chk("fwd_b_srcb", bus.SrcB, 32'd77);
      chk("fwd_b_store", bus.ex_store_data, 32'd77);
      fwd_off();

      // rs1=0 never forwards
      set_id(32'd11, 32'd22, 32'd0, 32'h108, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 4'd2, 1'b1);
      tick();
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd100;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd200;
      #1;
      chk("fwd_x0_a", bus.SrcA, 32'd11);
      chk("fwd_x0_b", bus.SrcB, 32'd22);
      fwd_off();

      // PC as SrcA
      set_id(32'd11, 32'd22, 32'd0, 32'h200, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 4'd2, 1'b1);
      tick();
      chk("a_sel_pc", bus.SrcA, 32'h200);

      // Shift amount masking
      set_id(32'd1, 32'h99, 32'h0000_0423, 32'h204, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 4'd3, 1'b1);
      tick();
      chk("slli_srcb", bus.SrcB, 32'h3);
      chk("slli_store", bus.ex_store_data, 32'h99);
      bus.id_operation = 4'd6;
      tick();
      chk("srai_srcb", bus.SrcB, 32'h3);
      bus.id_operation = 4'd4;
      tick();
      chk("srli_srcb", bus.SrcB, 32'h3);
      bus.id_operation = 4'd2;
      tick();
      chk("add_imm_srcb", bus.SrcB, 32'h423);

      // Stall two cycles; MEM/WB writes rs2=6 only in stall cycle 1
      set_id(32'd1, 32'd1, 32'd0, 32'h300, 5'd0, 5'd6, 5'd8, 1'b0, 1'b0, 4'd2, 1'b1);
      tick();
      bus.stall = 1'b1;
      set_id(32'd9, 32'd999, 32'd0, 32'h400, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 4'd2, 1'b1);
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd6; bus.memwb_result = 32'd55;
      #1;
      chk("stall1_srcb", bus.SrcB, 32'd55);
      tick();
      fwd_off();
      #1;
      chk("stall2_srcb", bus.SrcB, 32'd55);
      chk("stall2_store", bus.ex_store_data, 32'd55);
      chk("stall2_rd", 32'(bus.ex_rd), 32'd8);
      chk("stall2_pc", bus.ex_pc, 32'h300);
      tick();
      chk("stall3_srcb", bus.SrcB, 32'd55);
      chk("stall3_valid", 32'(bus.ex_valid), 32'd1);

      // Stall and flush together: flush wins
      bus.flush = 1'b1;
      tick();
      chk("sf_valid", 32'(bus.ex_valid), 32'd0);
      chk("sf_srca", bus.SrcA, 32'd0);
      chk("sf_srcb", bus.SrcB, 32'd0);
      chk("sf_op", 32'(bus.Operation), 32'd2);
      chk("sf_rw", 32'(bus.ex_reg_write), 32'd0);
      chk("sf_store", bus.ex_store_data, 32'd0);
      chk("sf_bc", 32'(bus.bubble_count), 32'd1);

      // id_valid=0 loads a bubble
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.id_valid = 1'b0;
      tick();
      chk("idv0_valid", 32'(bus.ex_valid), 32'd0);
      chk("idv0_rd", 32'(bus.ex_rd), 32'd0);
      chk("idv0_bc", 32'(bus.bubble_count), 32'd2);

      // Reset mid-stall wins
      set_id(32'd3, 32'd4, 32'd0, 32'h500, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 4'd2, 1'b1);
      tick();
      chk("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
      bus.stall = 1'b1;
      reset = 1'b1;
      tick();
      chk("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst_stall_pc", bus.ex_pc, 32'd0);
      chk("rst_stall_bc", 32'(bus.bubble_count), 32'd0);
      reset = 1'b0;
      bus.stall = 1'b0;

      // Saturation of bubble_count under a long flush
      bus.flush = 1'b1;
      for (int i = 0; i < 65534; i++) tick();
      chk("bc_fffe", 32'(bus.bubble_count), 32'hFFFE);
      for (int i = 0; i < 6; i++) tick();
      chk("bc_sat", 32'(bus.bubble_count), 32'hFFFF);
      reset = 1'b1;
      tick();
      chk("bc_rst", 32'(bus.bubble_count), 32'd0);
      reset = 1'b0;
      tick();
      chk("bc_after_rst", 32'(bus.bubble_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
